// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO bus bundle: UART byte strobe in, CPU register access
//
// Purpose: groups the UART receiver strobe and the CPU register-access signals of uart_rx_fifo.
// Signals:
//   rx_valid    UART receiver byte strobe (one cycle)
//   rx_byte     received byte
//   access_addr CPU register address
//   rd_en       CPU load commit strobe; pops at the data address
//   w_en        CPU store strobe
//   w_data      CPU store data
//   r_data      combinational read data (0x00 on a decode miss)
//   hit         access_addr decodes to a register of this block
//   int_req     registered level interrupt request
// Modports: master drives the strobes/address (CPU + receiver side), slave is the FIFO.
interface uart_rx_fifo_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] access_addr;
  logic       rd_en;
  logic       w_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       hit;
  logic       int_req;

  modport master (
    output rx_valid, rx_byte, access_addr, rd_en, w_en, w_data,
    input  r_data, hit, int_req
  );

  modport slave (
    input  rx_valid, rx_byte, access_addr, rd_en, w_en, w_data,
    output r_data, hit, int_req
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with memory-mapped data/status registers
//
// Purpose: buffers bytes strobed out of the UART receiver until firmware reads them through
// the data register; exposes status/control and raises a level interrupt while data waits.
// Ports:
//   clock   core clock, rising edge
//   reset   synchronous reset, active low
//   bus     uart_rx_fifo_if.slave (rx_valid, rx_byte, access_addr, rd_en, w_en, w_data,
//           r_data, hit, int_req)
// Registers:
//   DATA_ADDR  read: head byte (0x00 when empty); a committed read pops it
//   STAT_ADDR  read: {overflow, full, empty, count[4:0]}
//              write: bit7 clears overflow, bit0 flushes
//   THR_ADDR   interrupt threshold, only when UART_RX_FIFO_THRESH_EN is defined
// Option macro: UART_RX_FIFO_THRESH_EN adds the programmable threshold register.
module uart_rx_fifo #(
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] DATA_ADDR  = 8'd252,
  parameter logic [7:0] STAT_ADDR  = 8'd248,
  parameter logic [7:0] THR_ADDR   = 8'd247
) (
  input  logic          clock,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam int                  CW         = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]       FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]       CNT_ONE    = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  overflow;
  logic                  int_req_q;
  logic [7:0]            thr;

  logic is_data;
  logic is_stat;
  logic is_thr;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic ovf_evt;
  logic ctrl_wr;
  logic flush;
  logic ovf_clr;
  logic [7:0] status;

  assign is_data = (bus.access_addr == DATA_ADDR);
  assign is_stat = (bus.access_addr == STAT_ADDR);
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);

  assign pop     = bus.rd_en & is_data & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign push    = bus.rx_valid & (~full | pop);
  assign ovf_evt = bus.rx_valid & full & ~pop;

  assign ctrl_wr = bus.w_en & is_stat;
  assign flush   = ctrl_wr & bus.w_data[0];
  assign ovf_clr = ctrl_wr & bus.w_data[7];

  assign status  = {overflow, full, empty, 5'(count)};

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [7:0] DEPTH_BYTE = 8'(DEPTH);
  logic thr_wr;
  logic [7:0] thr_sat;

  assign is_thr = (bus.access_addr == THR_ADDR);
  assign thr_wr = bus.w_en & is_thr;

  // Threshold is kept in 1..DEPTH so the interrupt can always be reached and never fires when empty.
  always_comb begin
    thr_sat = bus.w_data;
    if (bus.w_data == 8'd0) begin
      thr_sat = 8'd1;
    end else if (bus.w_data > DEPTH_BYTE) begin
      thr_sat = DEPTH_BYTE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      thr <= 8'd1;
    end else if (thr_wr) begin
      thr <= thr_sat;
    end
  end
`else
  logic unused_w_data;

  assign is_thr        = 1'b0;
  assign thr           = 8'd1;
  assign unused_w_data = ^{bus.w_data[6:1], THR_ADDR};
`endif

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage has no reset: entries beyond count are never observable.
  always_ff @(posedge clock) begin
    if (reset && push && !flush) begin
      mem[wr_ptr] <= bus.rx_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      int_req_q <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
      count <= count_next;
      // A new overflow beats a same-cycle clear so the loss is never hidden.
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      int_req_q <= (8'(count_next) >= thr);
    end
  end

  always_comb begin
    bus.r_data = 8'h00;
    if (is_data) begin
      if (!empty) begin
        bus.r_data = mem[rd_ptr];
      end
    end else if (is_stat) begin
      bus.r_data = status;
    end else if (is_thr) begin
      bus.r_data = thr;
    end
  end

  assign bus.hit     = is_data | is_stat | is_thr;
  assign bus.int_req = int_req_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  localparam int         DEPTH     = 8;
  localparam logic [7:0] DATA_ADDR = 8'd252;
  localparam logic [7:0] STAT_ADDR = 8'd248;
  localparam logic [7:0] THR_ADDR  = 8'd247;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2(3),
    .DATA_ADDR (DATA_ADDR),
    .STAT_ADDR (STAT_ADDR),
    .THR_ADDR  (THR_ADDR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_int;
  int         m_thr;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] addr);
    int n;
    n = q.size();
    if (addr == DATA_ADDR) return (n > 0) ? q[0] : 8'h00;
    if (addr == STAT_ADDR) return {m_ovf, (n == DEPTH), (n == 0), 5'(n)};
`ifdef UART_RX_FIFO_THRESH_EN
    if (addr == THR_ADDR) return 8'(m_thr);
`endif
    return 8'h00;
  endfunction

  function automatic logic m_hit(input logic [7:0] addr);
`ifdef UART_RX_FIFO_THRESH_EN
    if (addr == THR_ADDR) return 1'b1;
`endif
    return (addr == DATA_ADDR) || (addr == STAT_ADDR);
  endfunction

  // Called right after a falling edge; one clock cycle elapses.
  task automatic step(input logic rxv, input logic [7:0] rxb, input logic [7:0] addr,
                      input logic rd, input logic we, input logic [7:0] wd,
                      output logic [7:0] obs);
    bit do_pop, dropped, do_flush;
    bus.rx_valid    = rxv;
    bus.rx_byte     = rxb;
    bus.access_addr = addr;
    bus.rd_en       = rd;
    bus.w_en        = we;
    bus.w_data      = wd;
    #1;
    obs = bus.r_data;
    check("r_data", bus.r_data, m_read(addr));
    check("hit", 8'(bus.hit), 8'(m_hit(addr)));
    check("int_req", 8'(bus.int_req), 8'(m_int));
    do_pop   = rd && addr == DATA_ADDR && q.size() > 0;
    dropped  = rxv && q.size() == DEPTH && !do_pop;
    do_flush = we && addr == STAT_ADDR && wd[0];
    if (dropped) m_ovf = 1'b1;
    else if (we && addr == STAT_ADDR && wd[7]) m_ovf = 1'b0;
    if (do_flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (rxv && !dropped) q.push_back(rxb);
    end
`ifdef UART_RX_FIFO_THRESH_EN
    if (we && addr == THR_ADDR) m_thr = (wd == 0) ? 1 : ((int'(wd) > DEPTH) ? DEPTH : int'(wd));
`endif
    m_int = (q.size() >= m_thr);
    @(negedge clock);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.w_en     = 1'b0;
    reset        = 1'b0;
    @(posedge clock);
    q.delete();
    m_ovf = 1'b0;
    m_int = 1'b0;
    m_thr = 1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    logic [7:0] o;
    step(1'b1, b, 8'h00, 1'b0, 1'b0, 8'h00, o);
  endtask

  task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    logic [7:0] o;
    step(1'b0, 8'h00, addr, 1'b0, 1'b0, 8'h00, o);
    check(tag, o, exp);
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    logic [7:0] o;
    step(1'b0, 8'h00, DATA_ADDR, 1'b1, 1'b0, 8'h00, o);
    check(tag, o, exp);
  endtask

  initial begin
    logic [7:0] o;
    logic [7:0] addr, wd;
    bus.rx_byte     = 8'h00;
    bus.access_addr = 8'h00;
    bus.w_data      = 8'h00;
    @(negedge clock);
    do_reset();

    read_reg(DATA_ADDR, 8'h00, "reset_data");
    read_reg(STAT_ADDR, 8'h20, "reset_stat");
    check("reset_int", 8'(bus.int_req), 8'h00);

    push(8'h41); push(8'h42); push(8'h43);
    read_reg(STAT_ADDR, 8'h03, "stat_three");
    check("int_three", 8'(bus.int_req), 8'h01);
    pop_expect(8'h41, "pop_a");
    pop_expect(8'h42, "pop_b");
    check("int_before_last", 8'(bus.int_req), 8'h01);
    pop_expect(8'h43, "pop_c");
    check("int_after_last", 8'(bus.int_req), 8'h00);
    read_reg(STAT_ADDR, 8'h20, "stat_drained");

    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    read_reg(STAT_ADDR, 8'hC8, "stat_overflow");
    for (int i = 0; i < 8; i++) pop_expect(8'h10 + 8'(i), "drain_order");
    read_reg(DATA_ADDR, 8'h00, "drain_empty");
    step(1'b0, 8'h00, STAT_ADDR, 1'b0, 1'b1, 8'h80, o);
    read_reg(STAT_ADDR, 8'h20, "stat_ovf_clear");

    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    step(1'b1, 8'h99, DATA_ADDR, 1'b1, 1'b0, 8'h00, o);
    check("full_pushpop_head", o, 8'h60);
    read_reg(STAT_ADDR, 8'h48, "full_pushpop_stat");
    for (int i = 1; i < 8; i++) pop_expect(8'h60 + 8'(i), "full_pushpop_drain");
    pop_expect(8'h99, "full_pushpop_tail");

    step(1'b1, 8'h77, DATA_ADDR, 1'b1, 1'b0, 8'h00, o);
    check("empty_pushpop", o, 8'h00);
    pop_expect(8'h77, "empty_pushpop_kept");

    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    do_reset();
    read_reg(STAT_ADDR, 8'h20, "midreset_stat");
    check("midreset_int", 8'(bus.int_req), 8'h00);
    push(8'h5A); push(8'h5B);
    pop_expect(8'h5A, "midreset_first");
    pop_expect(8'h5B, "midreset_second");

`ifdef UART_RX_FIFO_THRESH_EN
    step(1'b0, 8'h00, THR_ADDR, 1'b0, 1'b1, 8'd4, o);
    push(8'h01); push(8'h02); push(8'h03);
    check("thr_three", 8'(bus.int_req), 8'h00);
    push(8'h04);
    check("thr_four", 8'(bus.int_req), 8'h01);
    step(1'b0, 8'h00, THR_ADDR, 1'b0, 1'b1, 8'd0, o);
    read_reg(THR_ADDR, 8'd1, "thr_zero");
    step(1'b0, 8'h00, STAT_ADDR, 1'b0, 1'b1, 8'h01, o);
`else
    read_reg(THR_ADDR, 8'h00, "thr_undecoded");
`endif

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: addr = DATA_ADDR;
        1: addr = STAT_ADDR;
        2: addr = THR_ADDR;
        default: addr = 8'($urandom);
      endcase
      wd = 8'($urandom);
      if (addr == STAT_ADDR && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      step($urandom_range(0, 2) != 0, 8'($urandom), addr, 1'($urandom),
           $urandom_range(0, 7) == 0, wd, o);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
